mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control sequencer for the MIPS-subset core (R-type, lw, sw, bne, xori, j). It replaces single-cycle decode with a state machine that drives the shared ALU, unified instruction/data memory, IR and PC enables over several cycles per instruction. It stalls on a memory ready handshake and pulses a retire strobe at the end of each instruction.

## Interface
Parameters:
- None.

Ports:
- `clk`  in  1  core clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `mem_ready`  in  1  memory has completed the current read/write this cycle
- `pc_write`  out  1  unconditional PC load
- `pc_write_cond`  out  1  PC load if datapath `~Zero` (bne)
- `i_or_d`  out  1  0 = PC addresses memory, 1 = ALUOut
- `mem_read`  out  1  memory read request
- `mem_write`  out  1  memory write request
- `ir_write`  out  1  IR load
- `mem_to_reg`  out  1  write-back source: 1 = MDR, 0 = ALUOut
- `reg_dst`  out  1  1 = rd, 0 = rt
- `reg_write`  out  1  register file write
- `alu_src_a`  out  1  0 = PC, 1 = rs
- `alu_src_b`  out  2  00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
- `alu_op`  out  2  00 add, 01 sub, 10 funct, 11 xor
- `pc_source`  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- `sign_zero`  out  1  1 = zero-extend imm, 0 = sign-extend
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction
- `halted`  out  1  see Configuration

## Operation
- Moore FSM with a registered state; outputs are combinational from state. Exception: `ir_write`, `pc_write` and `instr_done` in memory states are ANDed with `mem_ready`.
- Any output not listed for a state is 0. `sign_zero` is 0 everywhere except IMM_EXEC.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`. Stay until `mem_ready`, then go to DECODE.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000101 -> BRANCH
  - 001110 -> IMM_EXEC
  - 000010 -> JUMP
  - other -> ILLEGAL
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next R_WB.
- R_WB: `reg_dst`=1, `reg_write`=1, `mem_to_reg`=0, `instr_done`=1. Next FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `i_or_d`=1. Hold until `mem_ready`, then MEM_WB.
- MEM_WB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1, `instr_done`=1. Next FETCH.
- MEM_WR: `mem_write`=1, `i_or_d`=1, `instr_done`=`mem_ready`. Hold until `mem_ready`, then FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. Next FETCH.
- IMM_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=11, `sign_zero`=1. Next IMM_WB.
- IMM_WB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1, `instr_done`=1. Next FETCH.
- JUMP: `pc_write`=1, `pc_source`=10, `instr_done`=1. Next FETCH.
- `mem_read` and `mem_write` are never asserted in the same cycle. `reg_write` and `pc_write` are never both 1 outside FETCH.

## Timing
- Cycles per instruction with `mem_ready` tied high: R 4, lw 5, sw 4, bne 3, xori 4, j 3.
- Each low cycle of `mem_ready` in FETCH, MEM_RD or MEM_WR adds exactly one cycle. All outputs stay stable while stalled.
- `opcode` is sampled only in DECODE and MEM_ADDR; its value in other states is ignored.
- Reset: `rst_n` low forces state to FETCH immediately, mid-instruction included. Outputs then show FETCH values: `mem_read`=1, `alu_src_b`=01, `ir_write`=`pc_write`=`mem_ready`, all others 0. `halted`=0.
- First fetch begins on the first rising edge after `rst_n` deasserts.

## Configuration
- `MC_CTRL_ILLEGAL_TRAP_EN` defined:
  - ILLEGAL is a terminal state with `halted`=1 and all other outputs 0.
  - It is left only by reset.
  - `instr_done` is not pulsed.
- Undefined:
  - ILLEGAL behaves as a NOP: `instr_done`=1 for one cycle, then FETCH.
  - `halted` is tied 0.

## Structure
- `mc_ctrl_pkg` holds:
  - the state enum
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BNE, OP_XORI, OP_J)
  - ALUOp, ALUSrcB and PCSource encodings
- One sub-module, `mc_opcode_class`: combinational opcode -> instruction class, used by DECODE and MEM_ADDR.

## Test plan
- Reset, then lw (100011) with `mem_ready`=1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; `instr_done` in cycle 5; `reg_write`=1 with `mem_to_reg`=1.
- sw with `mem_ready` low for 3 cycles in MEM_WR -> `mem_write` held 4 cycles, `instr_done` only on the ready cycle, 7 cycles total.
- bne (000101) -> 3 cycles; BRANCH has `pc_write_cond`=1, `alu_op`=01, `pc_source`=01.
- xori (001110) then j (000010) -> IMM_EXEC `sign_zero`=1 and `alu_op`=11; JUMP `pc_write`=1 and `pc_source`=10; 7 cycles total.
- Opcode 111111 -> with macro, `halted`=1 held for 10 cycles until reset; without macro, `instr_done` pulse and FETCH in cycle 3.
- `rst_n` pulsed low during MEM_RD -> state FETCH asynchronously, `mem_write`=0, `reg_write`=0; next lw completes normally.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS-subset control sequencer.
// Holds the state enum, the decoded instruction class, opcodes and datapath mux encodings.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_R_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_IMM_EXEC,
        S_IMM_WB,
        S_JUMP,
        S_ILLEGAL
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_LW,
        CLS_SW,
        CLS_BNE,
        CLS_XORI,
        CLS_J,
        CLS_ILL
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_XOR   = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_opcode_class.sv
// mc_opcode_class: combinational opcode -> instruction class lookup.
// Anything outside the supported subset maps to CLS_ILL.
module mc_opcode_class
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output iclass_t    o_class
);

    // Pure lookup, no state.
    always_comb begin
        case (i_opcode)
            OP_RTYPE: o_class = CLS_R;
            OP_LW:    o_class = CLS_LW;
            OP_SW:    o_class = CLS_SW;
            OP_BNE:   o_class = CLS_BNE;
            OP_XORI:  o_class = CLS_XORI;
            OP_J:     o_class = CLS_J;
            default:  o_class = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control sequencer (R-type, lw, sw, bne, xori, j).
// Moore outputs decoded from the state register; FETCH and MEM_WR qualify their
// write/retire strobes with mem_ready so a stalled cycle has no side effects.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN makes unknown opcodes halt the sequencer
// until reset; without it they retire as a NOP and halted is tied 0.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       sign_zero,
    output logic       instr_done,
    output logic       halted
);

    state_t  r_state;
    iclass_t w_class;

    mc_opcode_class u_class (
        .i_opcode (opcode),
        .o_class  (w_class)
    );

    // State register and transitions; opcode only matters in DECODE and MEM_ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:    if (mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (w_class)
                        CLS_R:            r_state <= S_EXEC;
                        CLS_LW, CLS_SW:   r_state <= S_MEM_ADDR;
                        CLS_BNE:          r_state <= S_BRANCH;
                        CLS_XORI:         r_state <= S_IMM_EXEC;
                        CLS_J:            r_state <= S_JUMP;
                        default:          r_state <= S_ILLEGAL;
                    endcase
                end
                S_EXEC:     r_state <= S_R_WB;
                S_MEM_ADDR: r_state <= (w_class == CLS_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:   if (mem_ready) r_state <= S_MEM_WB;
                S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
                S_IMM_EXEC: r_state <= S_IMM_WB;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                S_ILLEGAL:  r_state <= S_ILLEGAL;
`else
                S_ILLEGAL:  r_state <= S_FETCH;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Output decode: everything defaults low, each state raises only its own controls.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RT;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        sign_zero     = 1'b0;
        instr_done    = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SH;
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_XOR;
                sign_zero = 1'b1;
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL: halted = 1'b1;
`else
            S_ILLEGAL: instr_done = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: self-checking bench. Each instruction is expanded into its
// list of control steps (what the datapath must see each cycle), and the DUT
// outputs are compared against that every cycle under random memory stalls.
module tb_mc_control_fsm;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_XORI = 6'b001110;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_BAD  = 6'b111111;

    // observed bundle bit positions
    localparam logic [18:0] B_PCW  = 19'd1 << 18;
    localparam logic [18:0] B_PWC  = 19'd1 << 17;
    localparam logic [18:0] B_IOD  = 19'd1 << 16;
    localparam logic [18:0] B_MRD  = 19'd1 << 15;
    localparam logic [18:0] B_MWR  = 19'd1 << 14;
    localparam logic [18:0] B_IRW  = 19'd1 << 13;
    localparam logic [18:0] B_MTR  = 19'd1 << 12;
    localparam logic [18:0] B_RDST = 19'd1 << 11;
    localparam logic [18:0] B_RW   = 19'd1 << 10;
    localparam logic [18:0] B_SRCA = 19'd1 << 9;
    localparam logic [18:0] B_SZ   = 19'd1 << 2;
    localparam logic [18:0] B_DONE = 19'd1 << 1;
    localparam logic [18:0] B_HALT = 19'd1;

    typedef struct {
        logic [18:0] o;      // outputs regardless of mem_ready
        logic [18:0] rdy;    // extra outputs when mem_ready is high
        bit          waits;  // step repeats while mem_ready is low
        bit          samp;   // opcode must be valid during this step
    } ph_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opc = 6'd0;
    logic       mr = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, sign_zero, instr_done, halted;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [18:0] obs;

    int n_cmp = 0;
    int n_err = 0;
    ph_t plan[$];

    mc_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opc), .mem_ready(mr),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .sign_zero(sign_zero), .instr_done(instr_done),
        .halted(halted)
    );

    assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                  pc_source, sign_zero, instr_done, halted};

    always #5 clk = ~clk;

    function automatic logic [18:0] SB(input logic [1:0] v);
        return 19'(v) << 7;
    endfunction
    function automatic logic [18:0] AOP(input logic [1:0] v);
        return 19'(v) << 5;
    endfunction
    function automatic logic [18:0] PCS(input logic [1:0] v);
        return 19'(v) << 3;
    endfunction
    function automatic ph_t mk(input logic [18:0] o, input logic [18:0] rdy,
                               input bit waits, input bit samp);
        ph_t p;
        p.o = o; p.rdy = rdy; p.waits = waits; p.samp = samp;
        return p;
    endfunction

    // Cycles per instruction with memory always ready.
    function automatic int cpi(input logic [5:0] op);
        case (op)
            T_R:    return 4;
            T_LW:   return 5;
            T_SW:   return 4;
            T_BNE:  return 3;
            T_XORI: return 4;
            T_J:    return 3;
            default: return 3;
        endcase
    endfunction

    // Instruction -> sequence of control steps seen by the datapath.
    function automatic void build_plan(input logic [5:0] op);
        plan.delete();
        plan.push_back(mk(B_MRD | SB(2'b01), B_IRW | B_PCW, 1'b1, 1'b0));        // fetch, PC+4
        plan.push_back(mk(SB(2'b11), '0, 1'b0, 1'b1));                           // branch target calc
        case (op)
            T_R: begin
                plan.push_back(mk(B_SRCA | AOP(2'b10), '0, 1'b0, 1'b0));         // rs op rt
                plan.push_back(mk(B_RDST | B_RW | B_DONE, '0, 1'b0, 1'b0));      // write rd
            end
            T_LW: begin
                plan.push_back(mk(B_SRCA | SB(2'b10), '0, 1'b0, 1'b1));          // address
                plan.push_back(mk(B_MRD | B_IOD, '0, 1'b1, 1'b0));               // data read
                plan.push_back(mk(B_MTR | B_RW | B_DONE, '0, 1'b0, 1'b0));       // write rt from MDR
            end
            T_SW: begin
                plan.push_back(mk(B_SRCA | SB(2'b10), '0, 1'b0, 1'b1));          // address
                plan.push_back(mk(B_MWR | B_IOD, B_DONE, 1'b1, 1'b0));           // data write
            end
            T_BNE:
                plan.push_back(mk(B_SRCA | AOP(2'b01) | B_PWC | PCS(2'b01) | B_DONE, '0, 1'b0, 1'b0));
            T_XORI: begin
                plan.push_back(mk(B_SRCA | SB(2'b10) | AOP(2'b11) | B_SZ, '0, 1'b0, 1'b0));
                plan.push_back(mk(B_RW | B_DONE, '0, 1'b0, 1'b0));
            end
            T_J:
                plan.push_back(mk(B_PCW | PCS(2'b10) | B_DONE, '0, 1'b0, 1'b0));
            default:
                plan.push_back(mk(B_DONE, '0, 1'b0, 1'b0));                      // NOP retire
        endcase
    endfunction

    // Runs one instruction from FETCH, checking every cycle. Called at posedge+1.
    task automatic run_instr(input logic [5:0] op, input bit rnd, input int f_st,
                             input int m_st, input string nm,
                             output int cyc, output int lows);
        ph_t p;
        int w;
        bit adv;
        logic [18:0] ex;
        build_plan(op);
        cyc = 0;
        lows = 0;
        for (int i = 0; i < plan.size(); i++) begin
            p = plan[i];
            w = 0;
            adv = 1'b0;
            while (!adv) begin
                if (p.waits) begin
                    if (rnd) mr = (w >= 5) ? 1'b1 : ($urandom_range(0, 2) != 0);
                    else     mr = (w < ((i == 0) ? f_st : m_st)) ? 1'b0 : 1'b1;
                end else begin
                    mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                opc = (p.samp || !rnd) ? op : 6'($urandom);
                #1;
                cyc++;
                ex = p.o | (mr ? p.rdy : '0);
                n_cmp++;
                if (obs !== ex) begin
                    n_err++;
                    $display("FAIL %s step %0d cyc %0d: got %h want %h", nm, i, cyc, obs, ex);
                end
                @(posedge clk);
                #1;
                if (p.waits && !mr) begin
                    w++;
                    lows++;
                end else begin
                    adv = 1'b1;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mr = 1'b0;
        opc = T_LW;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== (B_MRD | SB(2'b01))) begin
            n_err++;
            $display("FAIL reset_idle: got %h want %h", obs, B_MRD | SB(2'b01));
        end
        mr = 1'b1;
        #1;
        n_cmp++;
        if (obs !== (B_MRD | SB(2'b01) | B_IRW | B_PCW)) begin
            n_err++;
            $display("FAIL reset_ready: got %h want %h", obs, B_MRD | SB(2'b01) | B_IRW | B_PCW);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_lw();
        int c, l;
        run_instr(T_LW, 1'b0, 0, 0, "lw", c, l);
        n_cmp++;
        if (c !== 5) begin n_err++; $display("FAIL lw_cycles: got %0d want 5", c); end
    endtask

    task automatic test_sw_stall();
        int c, l;
        run_instr(T_SW, 1'b0, 0, 3, "sw_stall", c, l);
        n_cmp++;
        if (c !== 7) begin n_err++; $display("FAIL sw_stall_cycles: got %0d want 7", c); end
    endtask

    task automatic test_bne();
        int c, l;
        run_instr(T_BNE, 1'b0, 0, 0, "bne", c, l);
        n_cmp++;
        if (c !== 3) begin n_err++; $display("FAIL bne_cycles: got %0d want 3", c); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, l;
        run_instr(T_XORI, 1'b0, 0, 0, "xori", c1, l);
        run_instr(T_J, 1'b0, 0, 0, "j", c2, l);
        n_cmp++;
        if (c1 + c2 !== 7) begin n_err++; $display("FAIL xori_j_cycles: got %0d want 7", c1 + c2); end
    endtask

    task automatic test_illegal();
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        opc = T_BAD;
        mr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            mr = 1'($urandom_range(0, 1));
            opc = 6'($urandom);
            #1;
            n_cmp++;
            if (obs !== B_HALT) begin
                n_err++;
                $display("FAIL illegal_halt cyc %0d: got %h want %h", k, obs, B_HALT);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        mr = 1'b0;
        #1;
        n_cmp++;
        if (obs !== (B_MRD | SB(2'b01))) begin
            n_err++;
            $display("FAIL illegal_reset: got %h want %h", obs, B_MRD | SB(2'b01));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`else
        int c, l;
        run_instr(T_BAD, 1'b0, 0, 0, "illegal_nop", c, l);
        n_cmp++;
        if (c !== 3) begin n_err++; $display("FAIL illegal_cycles: got %0d want 3", c); end
`endif
    endtask

    task automatic test_reset_mid();
        int c, l;
        opc = T_LW;
        mr = 1'b1;
        repeat (3) @(posedge clk);   // fetch, decode, address
        #1;
        mr = 1'b0;
        #1;
        n_cmp++;
        if (obs !== (B_MRD | B_IOD)) begin
            n_err++;
            $display("FAIL mid_memrd: got %h want %h", obs, B_MRD | B_IOD);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== (B_MRD | SB(2'b01))) begin
            n_err++;
            $display("FAIL mid_async_reset: got %h want %h", obs, B_MRD | SB(2'b01));
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(T_LW, 1'b0, 0, 0, "lw_after_reset", c, l);
        n_cmp++;
        if (c !== 5) begin n_err++; $display("FAIL lw_after_reset_cycles: got %0d want 5", c); end
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        logic [5:0] op;
        int c, l, nops;
        ops[0] = T_R; ops[1] = T_LW; ops[2] = T_SW; ops[3] = T_BNE;
        ops[4] = T_XORI; ops[5] = T_J; ops[6] = T_BAD;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        nops = 6;
`else
        nops = 7;
`endif
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, nops - 1)];
            run_instr(op, 1'b1, 0, 0, "random", c, l);
            n_cmp++;
            if (c !== cpi(op) + l) begin
                n_err++;
                $display("FAIL random_cycles op %b: got %0d want %0d", op, c, cpi(op) + l);
            end
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_bne();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
